// File: rtl/issue_queue.sv
// issue_queue: circular instruction buffer that issues each entry as one or
// more beats of parallel lane copies, narrowing to the backend lane limit.
module issue_queue #(
  parameter int INSTR_BITS            = 18,
  parameter int SUPERSCALAR_LOG_WIDTH = 2,
  parameter int QUEUE_LOG_DEPTH       = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [INSTR_BITS-1:0]            in_instr,
  input  logic [SUPERSCALAR_LOG_WIDTH-1:0] in_copy_count,
  output logic                             in_ready,
  input  logic [SUPERSCALAR_LOG_WIDTH-1:0] max_lanes,
  output logic                             out_valid,
  output logic [INSTR_BITS-1:0]            out_instr,
  output logic [(1<<SUPERSCALAR_LOG_WIDTH)-1:0] out_lane_mask,
  output logic [SUPERSCALAR_LOG_WIDTH-1:0] out_lane_base,
  output logic                             out_last,
  input  logic                             out_ready,
  output logic [QUEUE_LOG_DEPTH:0]         count
);
  localparam int SLW   = SUPERSCALAR_LOG_WIDTH;
  localparam int QLD   = QUEUE_LOG_DEPTH;
  localparam int SW    = 1 << SLW;
  localparam int DEPTH = 1 << QLD;
  localparam logic [QLD:0] FULL_CNT = (QLD+1)'(DEPTH);
  localparam logic [QLD:0] ONE_CNT  = (QLD+1)'(1);
  localparam logic [SLW:0] ONE_LANE = (SLW+1)'(1);

  typedef struct packed {
    logic [INSTR_BITS-1:0] instr;
    logic [SLW-1:0]        cc;
  } entry_t;

  entry_t         mem_q [DEPTH];
  entry_t         mem_d [DEPTH];
  logic [QLD-1:0] rd_ptr_q, rd_ptr_d;
  logic [QLD-1:0] wr_ptr_q, wr_ptr_d;
  logic [QLD:0]   count_q, count_d;
  logic [SLW-1:0] rem_q, rem_d;
  logic [SLW-1:0] base_q, base_d;

  logic [SLW:0]   lanes;
  logic [QLD-1:0] rd_next;
  logic           push, fire, pop;

  // Beat presentation from head entry and head-progress registers
  always_comb begin
    out_valid     = (count_q != '0);
    in_ready      = (count_q != FULL_CNT);
    count         = count_q;
    out_instr     = mem_q[rd_ptr_q].instr;
    out_lane_base = base_q;
    lanes         = (rem_q <= max_lanes) ? ({1'b0, rem_q} + ONE_LANE)
                                         : ({1'b0, max_lanes} + ONE_LANE);
    out_last      = out_valid && (rem_q <= max_lanes);
    out_lane_mask = '0;
    for (int unsigned j = 0; j < SW; j++) begin
      out_lane_mask[j] = out_valid && (j < 32'(lanes));
    end
  end

  // Next-state: storage, pointers, count and head progress
  always_comb begin
    push     = in_valid && in_ready;
    fire     = out_valid && out_ready;
    pop      = fire && out_last;
    rd_next  = rd_ptr_q + 1'b1;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    rem_d    = rem_q;
    base_d   = base_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{instr: in_instr, cc: in_copy_count};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_next;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase

    // The next head after a pop is either already stored, or is the entry
    // being pushed this very cycle when the queue held only the popping head.
    if (pop) begin
      base_d = '0;
      if (count_q > ONE_CNT) begin
        rem_d = mem_q[rd_next].cc;
      end else if (push) begin
        rem_d = in_copy_count;
      end else begin
        rem_d = '0;
      end
    end else if (fire) begin
      // Non-last beat: lanes <= rem < SW, so the low bits hold the full value.
      base_d = base_q + lanes[SLW-1:0];
      rem_d  = rem_q - lanes[SLW-1:0];
    end else if (push && (count_q == '0)) begin
      rem_d  = in_copy_count;
      base_d = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      rem_q    <= '0;
      base_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      base_q   <= base_d;
    end
  end
endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Instruction queue directly downstream of the loop controller; accepts one instruction per cycle tagged with its superscalar copy_count (0..3 encoding 1..4 copies).
- Buffers instructions and issues each one as one or more beats of parallel lane copies to the execution backend.
- Its in_ready is the loop controller's should_increment (stall when full).
- Splits an entry across several beats when the backend currently accepts fewer lanes than the entry's copy count.

Parameters:
- INSTR_BITS, 18, width of one instruction word.
- SUPERSCALAR_LOG_WIDTH, 2, log2 of lane count; SUPERSCALAR_WIDTH = 1 << SUPERSCALAR_LOG_WIDTH.
- QUEUE_LOG_DEPTH, 3, log2 of entry count; DEPTH = 1 << QUEUE_LOG_DEPTH.

Ports:
- clk  input  1  clock, all state on posedge.
- reset  input  1  synchronous, active-high; clears all state.
- in_valid  input  1  upstream presents an instruction this cycle.
- in_instr  input  INSTR_BITS  instruction word.
- in_copy_count  input  SUPERSCALAR_LOG_WIDTH  copies minus one (0 means 1 copy, 3 means 4 copies).
- in_ready  output  1  queue can accept; push happens when in_valid & in_ready.
- max_lanes  input  SUPERSCALAR_LOG_WIDTH  backend lane limit minus one, sampled every cycle.
- out_valid  output  1  a beat is presented.
- out_instr  output  INSTR_BITS  instruction of the head entry.
- out_lane_mask  output  SUPERSCALAR_WIDTH  thermometer mask of active lanes, bit 0 always set when out_valid.
- out_lane_base  output  SUPERSCALAR_LOG_WIDTH  copy index carried by lane 0; lane j executes copy out_lane_base+j.
- out_last  output  1  this beat completes the head entry.
- out_ready  input  1  backend takes the beat when out_valid & out_ready.
- count  output  QUEUE_LOG_DEPTH+1  entries currently stored, including a partially issued head.

Behaviour:
- Reset values:
  - in_ready=1, out_valid=0, out_lane_mask=0, out_lane_base=0, out_last=0, count=0.
  - Read and write pointers are 0.
  - Head remaining-copies register is 0.
- Storage:
  - Circular buffer of DEPTH entries {instr, copy_count}.
  - Pointers are QUEUE_LOG_DEPTH bits and wrap modulo DEPTH.
- in_ready = (count != DEPTH). It depends only on registered state.
- There is no push-through when full, even if a pop occurs in the same cycle.
- Latency: an entry pushed in cycle N can first appear on out_valid in cycle N+1. There is no same-cycle fall-through.
- out_valid = (count != 0). All out_* signals are driven from the head entry plus head-progress registers.
- Head progress state:
  - rem: copies still to issue, minus one.
  - base: next copy index.
  - Both are loaded from the head entry (rem = copy_count, base = 0) whenever a new entry becomes head.
- Per beat:
  - lanes = min(rem, max_lanes) + 1.
  - out_lane_mask has the low `lanes` bits set.
  - out_lane_base = base.
  - out_last = (rem <= max_lanes).
- On a handshake with out_last=0: base += lanes, rem -= lanes, and the entry stays.
- On a handshake with out_last=1:
  - The entry pops: read pointer advances, count decrements.
  - Head progress is reloaded from the next entry, or cleared to 0 if the queue becomes empty.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
  - A push into an empty queue while out_valid=0 cannot pop that same entry.
- max_lanes may change between beats of one entry. Each beat uses the current value, and base/rem stay consistent.
- out_* may change while out_valid & ~out_ready only through max_lanes changing. The backend must hold max_lanes stable while stalled.
- reset asserted mid-entry discards all entries and progress. The next cycle matches the reset values above.
- Copy counts never overflow: base + lanes <= SUPERSCALAR_WIDTH by construction. Width is SUPERSCALAR_LOG_WIDTH+1 internally for the sum.

Test Plan:
- Reset, then push instr 0x00011 with copy_count=3 and max_lanes=3, out_ready=1.
  - Next cycle: out_valid=1, mask=4'b1111, base=0, last=1.
  - Following cycle: count=0, out_valid=0.
- Push copy_count=3 with max_lanes=1.
  - Beat 1: mask=0011, base=0, last=0.
  - Beat 2: mask=0011, base=2, last=1.
  - Entry pops after beat 2.
- Push copy_count=2 with max_lanes=1, then change max_lanes to 0 after beat 1.
  - Beats: (0011, base 0, last 0), then (0001, base 2, last 1).
- Hold out_ready=0 and push 8 entries.
  - count=8 and in_ready=0.
  - A 9th in_valid is ignored.
  - Raise out_ready: entries drain in order with pointer wrap, and in_ready returns to 1 the cycle after the first pop.
- With count=4, push and complete a pop in the same cycle: count stays 4, and ordering is preserved across 20 random pushes and pops.
- Assert reset while the head is half-issued (base=2): the next cycle has out_valid=0, count=0, in_ready=1, and a fresh push issues with base=0.
